age_ordered_rs: RTL and testbench
=================================

Name: age_ordered_rs

Overview:
- Parametrised reservation station for a single pipelined/iterative functional unit (mul/div or similar).
- Generalises the single-FU station with the following:
  - configurable depth and CDB count;
  - true oldest-ready issue via an age matrix;
  - issue valid/ready handshake;
  - same-cycle CDB wakeup on insert;
  - flush;
  - free-entry count.
- Sits between rename/dispatch and the FU. It drives the PRF read addresses for the selected entry.

Parameters:
- DEPTH, 8, number of entries (>=2)
- CDB_WIDTH, 2, number of CDB broadcast ports
- PRF_IDX, 6, physical register index width
- ROB_IDX, 5, ROB id width
- ARCH_IDX, 5, architectural register index width
- OPC_W, 4, fu_opcode width
- CNT_W, $clog2(DEPTH+1), free-count width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  station can accept
- in_rob_id  in  ROB_IDX  ROB id
- in_rd_phy  in  PRF_IDX  destination physical register
- in_rd_arch  in  ARCH_IDX  destination architectural register
- in_opcode  in  OPC_W  FU opcode
- in_rs1_phy / in_rs2_phy  in  PRF_IDX  source physical registers
- in_rs1_rdy / in_rs2_rdy  in  1  source already available
- cdb_valid  in  CDB_WIDTH  per-port broadcast valid
- cdb_rd_phy  in  CDB_WIDTH*PRF_IDX  per-port tag, port k at bits [k*PRF_IDX +: PRF_IDX]
- iss_valid  out  1  an entry is selected
- iss_ready  in  1  FU accepts
- iss_rob_id / iss_rd_phy / iss_rd_arch / iss_opcode  out  selected entry fields
- prf_rs1_phy / prf_rs2_phy  out  PRF_IDX  PRF read addresses of the selected entry
- free_cnt  out  CNT_W  number of free entries (registered)

Behaviour:
- **Reset** (rst_n=0 at posedge):
  - all entries invalid; age matrix cleared; free_cnt=DEPTH.
  - Outputs in reset state: iss_valid=0, in_ready=1, iss_* and prf_* = 0.
- **Entry state:** valid, rob_id, rd_phy, rd_arch, opcode, rs1/rs2 phy and ready bits, plus older[i][j] (1 = i older than j).
- **in_ready** = (free_cnt != 0) && !flush.
  - Derived from start-of-cycle state only. A slot freed by a same-cycle issue is not reusable that cycle.
- **Insert** (in_valid && in_ready):
  - Target slot is the lowest-indexed invalid entry.
  - Source ready bit stored = in_rsX_rdy OR any cdb_valid[k] with matching tag in that cycle.
  - Age update for new entry n: older[n][*]=0 and older[j][n]=1 for every valid j.
  - The new entry is not issue-eligible until the next cycle.
- **Wakeup:** each cycle, for every valid entry and every k, a matching valid CDB tag sets the rsX ready bit.
- **Eligibility** (combinational): valid && (rs1 ready bit or CDB match this cycle) && (rs2 ready bit or CDB match this cycle).
- **Select:**
  - Pick eligible entry i such that no eligible j has older[j][i]=1. Exactly one winner exists.
  - iss_valid = any eligible && !flush.
  - iss_* and prf_* show the winner's fields; they are 0 when iss_valid=0.
  - iss_* may change while iss_valid && !iss_ready. The FU must not assume stability (no hold requirement).
- **Issue:** iss_valid && iss_ready frees the winner at the next edge and clears its older row/column.
- **free_cnt** next = free_cnt − insert + issue. Insert and issue in the same cycle leaves it unchanged.
- **flush:** highest priority.
  - Next edge: all entries invalid, age cleared, free_cnt=DEPTH.
  - Insert and issue that cycle are suppressed (in_ready=0, iss_valid=0).
- **Reset priority:** reset mid-operation overrides flush, insert and issue.
- **Full:** free_cnt=0 → in_ready=0, even if issuing that cycle.
- **Tag 0:** no special handling; CDB never broadcasts it for real writes.

Test Plan:
1. Reset, DEPTH=4 → free_cnt=4, in_ready=1, iss_valid=0. Insert rob 1 (rs1_rdy=1, rs2_rdy=1); next cycle iss_valid=1, iss_rob_id=1, prf_rs1_phy=in value. iss_ready=1 → free_cnt returns to 4.
2. Age order: insert rob 3 (rs1_phy=10 not ready) into slot 0, then rob 4 (rs1_phy=11 not ready) into slot 1, then rob 5 (both ready) into slot 2.
   - Issue rob 5 first.
   - CDB k=0 broadcasts 11, then k=1 broadcasts 10 a cycle later → rob 4 issues before rob 3.
   - Re-run with both broadcast in the same cycle → rob 3 issues first (oldest).
3. Same-cycle insert wakeup: insert rs2_phy=20 not ready while cdb_valid[1]=1, tag 20 → entry issues the following cycle without further broadcast.
4. Full: fill 4 entries with unready sources → free_cnt=0, in_ready=0. Wake one and issue with in_valid=1 → no insert that cycle; next cycle in_ready=1, insert lands in the freed slot.
5. Backpressure: eligible entry, iss_ready=0 for 3 cycles → iss_valid held 1, free_cnt unchanged. iss_ready=1 → freed.
6. Flush with 3 entries plus simultaneous in_valid and eligible issue → iss_valid=0 and in_ready=0 that cycle; next cycle free_cnt=4, no entry issues. Repeat using rst_n=0 instead → same result.

Source files
------------

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station for one pipelined/iterative functional unit.
// Issues the oldest ready entry using an age matrix; supports CDB wakeup, flush and backpressure.
module age_ordered_rs #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CDB_WIDTH = 2,
    parameter int unsigned PRF_IDX   = 6,
    parameter int unsigned ROB_IDX   = 5,
    parameter int unsigned ARCH_IDX  = 5,
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROB_IDX-1:0]            in_rob_id,
    input  logic [PRF_IDX-1:0]            in_rd_phy,
    input  logic [ARCH_IDX-1:0]           in_rd_arch,
    input  logic [OPC_W-1:0]              in_opcode,
    input  logic [PRF_IDX-1:0]            in_rs1_phy,
    input  logic [PRF_IDX-1:0]            in_rs2_phy,
    input  logic                          in_rs1_rdy,
    input  logic                          in_rs2_rdy,
    input  logic [CDB_WIDTH-1:0]          cdb_valid,
    input  logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [ROB_IDX-1:0]            iss_rob_id,
    output logic [PRF_IDX-1:0]            iss_rd_phy,
    output logic [ARCH_IDX-1:0]           iss_rd_arch,
    output logic [OPC_W-1:0]              iss_opcode,
    output logic [PRF_IDX-1:0]            prf_rs1_phy,
    output logic [PRF_IDX-1:0]            prf_rs2_phy,
    output logic [CNT_W-1:0]              free_cnt
);

    logic [DEPTH-1:0]    valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [ROB_IDX-1:0]  rob_q [DEPTH];
    logic [ROB_IDX-1:0]  rob_d [DEPTH];
    logic [PRF_IDX-1:0]  rd_q [DEPTH];
    logic [PRF_IDX-1:0]  rd_d [DEPTH];
    logic [ARCH_IDX-1:0] arch_q [DEPTH];
    logic [ARCH_IDX-1:0] arch_d [DEPTH];
    logic [OPC_W-1:0]    opc_q [DEPTH];
    logic [OPC_W-1:0]    opc_d [DEPTH];
    logic [PRF_IDX-1:0]  rs1_q [DEPTH];
    logic [PRF_IDX-1:0]  rs1_d [DEPTH];
    logic [PRF_IDX-1:0]  rs2_q [DEPTH];
    logic [PRF_IDX-1:0]  rs2_d [DEPTH];
    // older_q[i][j] = 1 when entry i is older than entry j
    logic [DEPTH-1:0]    older_q [DEPTH];
    logic [DEPTH-1:0]    older_d [DEPTH];
    logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;

    logic [DEPTH-1:0] hit1, hit2, elig, win, ins_oh, keep;
    logic             ins_hit1, ins_hit2, ins_found, ins, iss_fire;

    always_comb begin
        hit1     = '0;
        hit2     = '0;
        ins_hit1 = 1'b0;
        ins_hit2 = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cdb_valid[k]) begin
                if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == in_rs1_phy) ins_hit1 = 1'b1;
                if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == in_rs2_phy) ins_hit2 = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == rs1_q[i]) hit1[i] = 1'b1;
                    if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == rs2_q[i]) hit2[i] = 1'b1;
                end
            end
        end
        elig = valid_q & (rs1_rdy_q | hit1) & (rs2_rdy_q | hit2);

        // Winner: eligible and no eligible entry is older than it.
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = elig[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (elig[j] && older_q[j][i]) win[i] = 1'b0;
            end
        end

        ins_oh    = '0;
        ins_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !ins_found) begin
                ins_oh[i] = 1'b1;
                ins_found = 1'b1;
            end
        end
    end

    assign in_ready  = (free_cnt_q != '0) && !flush;
    assign iss_valid = (|elig) && !flush;
    assign ins       = in_valid && in_ready;
    assign iss_fire  = iss_valid && iss_ready;
    assign keep      = valid_q & ~(win & {DEPTH{iss_fire}});
    assign free_cnt  = free_cnt_q;

    always_comb begin
        iss_rob_id  = '0;
        iss_rd_phy  = '0;
        iss_rd_arch = '0;
        iss_opcode  = '0;
        prf_rs1_phy = '0;
        prf_rs2_phy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (win[i] && iss_valid) begin
                iss_rob_id  = iss_rob_id | rob_q[i];
                iss_rd_phy  = iss_rd_phy | rd_q[i];
                iss_rd_arch = iss_rd_arch | arch_q[i];
                iss_opcode  = iss_opcode | opc_q[i];
                prf_rs1_phy = prf_rs1_phy | rs1_q[i];
                prf_rs2_phy = prf_rs2_phy | rs2_q[i];
            end
        end
    end

    always_comb begin
        valid_d    = keep;
        rs1_rdy_d  = rs1_rdy_q | hit1;
        rs2_rdy_d  = rs2_rdy_q | hit2;
        free_cnt_d = free_cnt_q - CNT_W'(ins) + CNT_W'(iss_fire);
        for (int i = 0; i < DEPTH; i++) begin
            rob_d[i]   = rob_q[i];
            rd_d[i]    = rd_q[i];
            arch_d[i]  = arch_q[i];
            opc_d[i]   = opc_q[i];
            rs1_d[i]   = rs1_q[i];
            rs2_d[i]   = rs2_q[i];
            older_d[i] = older_q[i] & keep;
            if (!keep[i]) older_d[i] = '0;
        end
        if (ins) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ins_oh[i]) begin
                    valid_d[i]   = 1'b1;
                    rob_d[i]     = in_rob_id;
                    rd_d[i]      = in_rd_phy;
                    arch_d[i]    = in_rd_arch;
                    opc_d[i]     = in_opcode;
                    rs1_d[i]     = in_rs1_phy;
                    rs2_d[i]     = in_rs2_phy;
                    rs1_rdy_d[i] = in_rs1_rdy | ins_hit1;
                    rs2_rdy_d[i] = in_rs2_rdy | ins_hit2;
                    older_d[i]   = '0;
                    for (int j = 0; j < DEPTH; j++) older_d[j][i] = keep[j];
                end
            end
        end
        if (flush) begin
            valid_d    = '0;
            free_cnt_d = CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            rs1_rdy_q  <= '0;
            rs2_rdy_q  <= '0;
            free_cnt_q <= CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]   <= '0;
                rd_q[i]    <= '0;
                arch_q[i]  <= '0;
                opc_q[i]   <= '0;
                rs1_q[i]   <= '0;
                rs2_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rs1_rdy_q  <= rs1_rdy_d;
            rs2_rdy_q  <= rs2_rdy_d;
            free_cnt_q <= free_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]   <= rob_d[i];
                rd_q[i]    <= rd_d[i];
                arch_q[i]  <= arch_d[i];
                opc_q[i]   <= opc_d[i];
                rs1_q[i]   <= rs1_d[i];
                rs2_q[i]   <= rs2_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs (DEPTH=4): expected issue order is queued at dispatch
// and popped as the station issues.
module tb_age_ordered_rs;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rob_id, in_rd_arch;
    logic [5:0]  in_rd_phy, in_rs1_phy, in_rs2_phy;
    logic [3:0]  in_opcode;
    logic        in_rs1_rdy, in_rs2_rdy;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_rd_phy;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rob_id, iss_rd_arch;
    logic [5:0]  iss_rd_phy, prf_rs1_phy, prf_rs2_phy;
    logic [3:0]  iss_opcode;
    logic [CNT_W-1:0] free_cnt;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    age_ordered_rs #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
        .in_rd_phy(in_rd_phy), .in_rd_arch(in_rd_arch), .in_opcode(in_opcode),
        .in_rs1_phy(in_rs1_phy), .in_rs2_phy(in_rs2_phy),
        .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_id(iss_rob_id),
        .iss_rd_phy(iss_rd_phy), .iss_rd_arch(iss_rd_arch), .iss_opcode(iss_opcode),
        .prf_rs1_phy(prf_rs1_phy), .prf_rs2_phy(prf_rs2_phy), .free_cnt(free_cnt)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one cycle and return to the negative edge with idle inputs.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        cdb_valid = 2'b00;
        iss_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic ins(input int rob, input int rs1, input bit r1, input int rs2, input bit r2);
        in_valid   = 1'b1;
        in_rob_id  = 5'(rob);
        in_rd_phy  = 6'(rob + 32);
        in_rd_arch = 5'(rob);
        in_opcode  = 4'(rob);
        in_rs1_phy = 6'(rs1);
        in_rs2_phy = 6'(rs2);
        in_rs1_rdy = r1;
        in_rs2_rdy = r2;
        step();
    endtask

    // Accept whatever the station issues this cycle and compare against the scoreboard.
    task automatic issue_pop(input string tag);
        int e;
        #1;
        chk({tag, "_valid"}, int'(iss_valid), 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, int'(iss_rob_id), -1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rob"}, int'(iss_rob_id), e);
        end
        iss_ready = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0;
        cdb_valid = 2'b00; cdb_rd_phy = '0;
        in_rob_id = '0; in_rd_phy = '0; in_rd_arch = '0; in_opcode = '0;
        in_rs1_phy = '0; in_rs2_phy = '0; in_rs1_rdy = 1'b0; in_rs2_rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // 1. reset state and single issue
        #1;
        chk("rst_free", int'(free_cnt), 4);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_iss_valid", int'(iss_valid), 0);
        chk("rst_iss_rob", int'(iss_rob_id), 0);
        chk("rst_prf_rs1", int'(prf_rs1_phy), 0);
        in_valid = 1'b1;
        #1;
        chk("t1_not_same_cycle", int'(iss_valid), 0);
        exp_q.push_back(1);
        ins(1, 7, 1, 8, 1);
        #1;
        chk("t1_free", int'(free_cnt), 3);
        chk("t1_prf_rs1", int'(prf_rs1_phy), 7);
        chk("t1_prf_rs2", int'(prf_rs2_phy), 8);
        chk("t1_rd_phy", int'(iss_rd_phy), 33);
        chk("t1_rd_arch", int'(iss_rd_arch), 1);
        chk("t1_opcode", int'(iss_opcode), 1);
        issue_pop("t1_issue");
        #1;
        chk("t1_free_back", int'(free_cnt), 4);
        chk("t1_idle", int'(iss_valid), 0);

        // 2. age order with staggered then simultaneous wakeups
        exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(3);
        ins(3, 10, 0, 1, 1);
        ins(4, 11, 0, 1, 1);
        ins(5, 2, 1, 1, 1);
        issue_pop("t2_ready_first");
        cdb_valid = 2'b01; cdb_rd_phy = {6'd0, 6'd11};
        issue_pop("t2_wake11");
        cdb_valid = 2'b10; cdb_rd_phy = {6'd10, 6'd0};
        issue_pop("t2_wake10");
        #1;
        chk("t2_free", int'(free_cnt), 4);
        exp_q.push_back(3); exp_q.push_back(4);
        ins(3, 10, 0, 1, 1);
        ins(4, 11, 0, 1, 1);
        #1;
        chk("t2b_none_ready", int'(iss_valid), 0);
        cdb_valid = 2'b11; cdb_rd_phy = {6'd10, 6'd11};
        issue_pop("t2b_oldest");
        issue_pop("t2b_latched");

        // 3. wakeup captured on the insert cycle
        exp_q.push_back(6);
        cdb_valid = 2'b10; cdb_rd_phy = {6'd20, 6'd0};
        ins(6, 1, 1, 20, 0);
        issue_pop("t3_ins_wake");

        // 4. full station
        for (int r = 8; r < 12; r++) ins(r, 32 + r, 0, 1, 1);
        #1;
        chk("t4_free0", int'(free_cnt), 0);
        chk("t4_in_ready0", int'(in_ready), 0);
        exp_q.push_back(10);
        cdb_valid = 2'b01; cdb_rd_phy = {6'd0, 6'd42};
        in_valid = 1'b1; in_rob_id = 5'd12; in_rs1_rdy = 1'b1; in_rs2_rdy = 1'b1;
        #1;
        chk("t4_no_ready_while_issuing", int'(in_ready), 0);
        issue_pop("t4_issue");
        #1;
        chk("t4_free1", int'(free_cnt), 1);
        chk("t4_in_ready1", int'(in_ready), 1);
        exp_q.push_back(12); exp_q.push_back(8); exp_q.push_back(9); exp_q.push_back(11);
        ins(12, 1, 1, 2, 1);
        #1;
        chk("t4_refull", int'(free_cnt), 0);
        issue_pop("t4_new");
        cdb_valid = 2'b11; cdb_rd_phy = {6'd41, 6'd40};
        issue_pop("t4_old8");
        cdb_valid = 2'b01; cdb_rd_phy = {6'd0, 6'd43};
        issue_pop("t4_old9");
        issue_pop("t4_old11");
        #1;
        chk("t4_empty", int'(free_cnt), 4);

        // 5. backpressure
        exp_q.push_back(13);
        ins(13, 1, 1, 2, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t5_hold_valid", int'(iss_valid), 1);
            chk("t5_hold_free", int'(free_cnt), 3);
            step();
        end
        issue_pop("t5_release");
        #1;
        chk("t5_free", int'(free_cnt), 4);

        // 6. flush, then the same with reset
        for (int r = 14; r < 17; r++) ins(r, 1, 1, 2, 1);
        flush = 1'b1; in_valid = 1'b1; in_rob_id = 5'd17; iss_ready = 1'b1;
        #1;
        chk("t6_flush_iss", int'(iss_valid), 0);
        chk("t6_flush_in_ready", int'(in_ready), 0);
        chk("t6_flush_rob", int'(iss_rob_id), 0);
        step();
        #1;
        chk("t6_free", int'(free_cnt), 4);
        chk("t6_none", int'(iss_valid), 0);
        for (int r = 18; r < 21; r++) ins(r, 1, 1, 2, 1);
        rst_n = 1'b0; in_valid = 1'b1; in_rob_id = 5'd21; iss_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        chk("t6r_free", int'(free_cnt), 4);
        chk("t6r_none", int'(iss_valid), 0);
        chk("t6r_in_ready", int'(in_ready), 1);
        step();
        #1;
        chk("t6r_still_none", int'(iss_valid), 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
